// File: rtl/ifu_defs.sv
// Shared definitions for the instruction fetch unit: FSM encodings and PC constants.
// The HALT state exists only when IFU_ALIGN_CHECK_EN is defined.
package ifu_defs;

    localparam logic [31:0] PC_RESET_DFLT = 32'h0000_3000;
    localparam logic [31:0] PC_STEP       = 32'd4;

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3
    } state_t;
`endif

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection: jr > jal > taken beq > pc+4.
// Without IFU_ALIGN_CHECK_EN the jr target is forced word-aligned.
module npc
    import ifu_defs::*;
(
    input  logic [31:0] pc4,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jal,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] jr_pc;
    logic [31:0] jal_pc;
    logic [31:0] br_pc;

`ifdef IFU_ALIGN_CHECK_EN
    assign jr_pc = jr_target;
`else
    assign jr_pc = jr_target & ~32'd3;
`endif

    assign jal_pc = {pc4[31:28], j_index, 2'b00};
    // Sign-extended word offset; wrap-around is intentionally modulo 2^32.
    assign br_pc  = pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jr)
            next_pc = jr_pc;
        else if (jal)
            next_pc = jal_pc;
        else if (br_taken)
            next_pc = br_pc;
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, fetch FSM over a req/gnt/rvalid memory port,
// and instruction latch. IFU_ALIGN_CHECK_EN enables misaligned-jr detection and HALT.
module ifu
    import ifu_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jal,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        align_err
);

    state_t      state, next_state;
    logic [31:0] next_pc;
    logic        load_pc;
    logic        misaligned;

    assign pc4     = pc + PC_STEP;
    assign im_addr = pc;

    npc u_npc (
        .pc4       (pc4),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .jal       (jal),
        .j_index   (j_index),
        .jr        (jr),
        .jr_target (jr_target),
        .next_pc   (next_pc)
    );

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned = (next_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        next_state = state;
        load_pc    = 1'b0;
        case (state)
            S_BOOT: next_state = S_REQ;
            S_REQ:  if (im_gnt)    next_state = S_WAIT;
            S_WAIT: if (im_rvalid) next_state = S_HOLD;
            S_HOLD: begin
                if (advance) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (misaligned) begin
                        next_state = S_HALT;
                    end else begin
                        next_state = S_REQ;
                        load_pc    = 1'b1;
                    end
`else
                    next_state = S_REQ;
                    load_pc    = 1'b1;
`endif
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_HALT: next_state = S_HALT;
`endif
            default: next_state = S_BOOT;
        endcase
    end

    // im_req and instr_valid are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_BOOT;
            pc          <= PC_RESET;
            im_req      <= 1'b0;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            state       <= next_state;
            im_req      <= (next_state == S_REQ);
            instr_valid <= (next_state == S_HOLD);
            if (load_pc)
                pc <= next_pc;
            if (state == S_WAIT && im_rvalid)
                instr <= im_rdata;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            align_err <= 1'b0;
        else if (state == S_HOLD && advance && misaligned)
            align_err <= 1'b1;
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: fetch handshake, next-PC priority, reset mid-fetch.
module tb_ifu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        advance = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = 16'd0;
    logic        jal = 1'b0;
    logic [25:0] j_index = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt = 1'b0;
    logic        im_rvalid = 1'b0;
    logic [31:0] im_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        align_err;

    int total = 0;
    int passed = 0;

    ifu dut (
        .clk(clk), .reset(reset), .advance(advance),
        .br_taken(br_taken), .br_offset(br_offset),
        .jal(jal), .j_index(j_index), .jr(jr), .jr_target(jr_target),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc4(pc4), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory model: grant after gdly cycles in REQ, respond rdly cycles after the grant.
    task automatic fetch(input string tag, input logic [31:0] addr, input int gdly,
                         input int rdly, input logic [31:0] data);
        int n = 0;
        while (im_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(im_req), 32'd1);
        chk({tag, "_addr"}, im_addr, addr);
        repeat (gdly) @(negedge clk);
        im_gnt = 1'b1;
        @(negedge clk);
        im_gnt = 1'b0;
        chk({tag, "_req_drop"}, 32'(im_req), 32'd0);
        repeat (rdly - 1) @(negedge clk);
        chk({tag, "_not_yet_valid"}, 32'(instr_valid), 32'd0);
        im_rvalid = 1'b1;
        im_rdata  = data;
        @(negedge clk);
        im_rvalid = 1'b0;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_instr"}, instr, data);
        chk({tag, "_no_req_in_hold"}, 32'(im_req), 32'd0);
    endtask

    task automatic adv(input string tag, input logic b, input logic [15:0] off, input logic jl,
                       input logic [25:0] idx, input logic r, input logic [31:0] tgt,
                       input logic [31:0] exp_pc);
        advance = 1'b1; br_taken = b; br_offset = off; jal = jl; j_index = idx;
        jr = r; jr_target = tgt;
        @(negedge clk);
        advance = 1'b0; br_taken = 1'b0; jal = 1'b0; jr = 1'b0;
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_pc4"}, pc4, exp_pc + 32'd4);
        chk({tag, "_valid_clr"}, 32'(instr_valid), 32'd0);
        chk({tag, "_req"}, 32'(im_req), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", 32'(im_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_align", 32'(align_err), 32'd0);
        reset = 1'b1;

        fetch("f0", 32'h0000_3000, 0, 1, 32'h3C01_1234);
        chk("f0_pc4", pc4, 32'h0000_3004);

        // advance held high across a whole fetch; it only matters in HOLD
        advance = 1'b1;
        @(negedge clk);
        chk("seq_pc1", pc, 32'h0000_3004);
        fetch("seq1", 32'h0000_3004, 0, 3, 32'h2002_0005);
        @(negedge clk);
        advance = 1'b0;
        chk("seq_pc2", pc, 32'h0000_3008);
        fetch("seq2", 32'h0000_3008, 2, 2, 32'h1000_FFFF);

        adv("beq_back", 1'b1, 16'hFFFF, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_3008);
        fetch("f_beq1", 32'h0000_3008, 1, 1, 32'h1000_0002);
        adv("beq_fwd", 1'b1, 16'h0002, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_3014);
        fetch("f_beq2", 32'h0000_3014, 0, 1, 32'h03E0_0008);
        adv("jr_home", 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h0000_3000, 32'h0000_3000);
        fetch("f_jr", 32'h0000_3000, 0, 1, 32'h0C00_0C10);
        adv("jal", 1'b0, 16'd0, 1'b1, 26'h0000C10, 1'b0, 32'd0, 32'h0000_3040);
        fetch("f_jal", 32'h0000_3040, 0, 2, 32'h0000_0000);
        adv("jr_wins", 1'b1, 16'h0010, 1'b1, 26'h0000C10, 1'b1, 32'h0000_3100, 32'h0000_3100);
        fetch("f_jrw", 32'h0000_3100, 0, 1, 32'h1234_5678);
        adv("jr_top", 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch("f_top", 32'hFFFF_FFFC, 0, 1, 32'h0000_0000);
        adv("wrap", 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_0000);

        // grant, then pull reset while WAIT is outstanding
        im_gnt = 1'b1;
        @(negedge clk);
        im_gnt = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0000_3000);
        chk("mid_rst_req", 32'(im_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        im_rvalid = 1'b1;
        im_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        im_rvalid = 1'b0;
        chk("late_req", 32'(im_req), 32'd1);
        chk("late_addr", im_addr, 32'h0000_3000);
        chk("late_valid", 32'(instr_valid), 32'd0);
        chk("late_instr", instr, 32'd0);
        fetch("f_post", 32'h0000_3000, 1, 1, 32'h03E0_0008);

        advance = 1'b1; jr = 1'b1; jr_target = 32'h0000_3002;
        @(negedge clk);
        advance = 1'b0; jr = 1'b0;
        chk("mis_pc", pc, 32'h0000_3000);
        chk("mis_valid", 32'(instr_valid), 32'd0);
`ifdef IFU_ALIGN_CHECK_EN
        chk("mis_align", 32'(align_err), 32'd1);
        chk("mis_req", 32'(im_req), 32'd0);
        im_gnt = 1'b1; im_rvalid = 1'b1; advance = 1'b1;
        repeat (5) @(negedge clk);
        im_gnt = 1'b0; im_rvalid = 1'b0; advance = 1'b0;
        chk("halt_req", 32'(im_req), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_align", 32'(align_err), 32'd1);
        chk("halt_pc", pc, 32'h0000_3000);
`else
        chk("mis_align", 32'(align_err), 32'd0);
        chk("mis_req", 32'(im_req), 32'd1);
        fetch("f_mis", 32'h0000_3000, 0, 1, 32'hAAAA_5555);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
